// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to instruction
// memory, and buffers in-order responses as {pc, instr} pairs presented to IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        FetchValidF
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(IBUF_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   pc_mem_q    [IBUF_DEPTH];
  logic [31:0]   instr_mem_q [IBUF_DEPTH];

  logic [CW:0] credit_used;
  logic        grant, kill_resp, push, pop, q_empty;

  // Handshake: a request transfers in any cycle where imem_req & imem_gnt; until then
  // imem_req/imem_addr hold steady (credits only free up while waiting). Responses carry
  // no PC; responses surviving a redirect are contiguous from the target, so resp_pc tracks it.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req    = reset && !PCSrcE && (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc_q;
  assign grant       = imem_req && imem_gnt;
  assign kill_resp   = imem_rvalid && (kill_cnt_q != '0);
  assign push        = imem_rvalid && !kill_resp && !PCSrcE;
  assign q_empty     = (count_q == '0);
  assign pop         = !q_empty && !StallF && !PCSrcE;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    kill_cnt_d    = kill_cnt_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    if (PCSrcE) begin
      // Everything still in flight after this cycle belongs to the wrong path.
      fetch_pc_d = PCTargetE & 32'hFFFF_FFFC;
      resp_pc_d  = PCTargetE & 32'hFFFF_FFFC;
      kill_cnt_d = outstanding_q - CW'(imem_rvalid);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (grant)     fetch_pc_d = fetch_pc_q + 32'd4;
      if (kill_resp) kill_cnt_d = kill_cnt_q - 1'b1;
      if (push) begin
        tail_d    = tail_q + 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Queue storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= resp_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

  assign FetchValidF = !q_empty;
  assign PCF         = q_empty ? 32'h0 : pc_mem_q[head_q];
  assign InstrF      = q_empty ? 32'h0 : instr_mem_q[head_q];
  assign PCplus4F    = q_empty ? 32'h0 : pc_mem_q[head_q] + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable in-order memory model, expected-PC
// scoreboard checked on every consumed instruction, plus directed timing checks.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] SIG    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrF, PCF, PCplus4F;
  logic        FetchValidF;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(RST_PC), .IBUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCplus4F(PCplus4F), .FetchValidF(FetchValidF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic load_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset(input int new_lat);
    reset    = 1'b0;
    StallF   = 1'b0;
    PCSrcE   = 1'b0;
    imem_gnt = 1'b1;
    repeat (2) next_cycle();
    exp_q.delete();
    lat = new_lat;
  endtask

  task automatic wait_first_valid(input string tag, input logic [31:0] pc, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (FetchValidF) break;
      next_cycle();
    end
    check({tag, "_valid"}, 32'(FetchValidF), 32'd1);
    check({tag, "_pc"}, PCF, pc);
    check({tag, "_instr"}, InstrF, pc ^ SIG);
  endtask

  // Memory model: fixed latency, in order, response data = addr ^ SIG.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        mreq_t r;
        r = mem_q.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = r.addr ^ SIG;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && imem_req && imem_gnt) begin
      mreq_t r;
      r.addr = imem_addr;
      r.due  = cyc + lat;
      mem_q.push_back(r);
    end
  end

  // Scoreboard: every instruction IF/ID consumes must be the next expected PC.
  always @(negedge clk) begin
    if (reset) begin
      if (!FetchValidF) begin
        check("bubble_zero", InstrF | PCF | PCplus4F, 32'h0);
      end else if (!StallF && !PCSrcE) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_pc", PCF, e);
          check("sb_instr", InstrF, e ^ SIG);
          check("sb_pc4", PCplus4F, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    check("watchdog", 32'(n_checks), 32'hFFFF_FFFF);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] snap_pc, snap_instr, snap_pc4, snap_addr;
    reset = 1'b1;
    StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; imem_gnt = 1'b1;
    #1;
    reset = 1'b0;
    repeat (3) next_cycle();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(FetchValidF), 32'd0);
    check("rst_outs", InstrF | PCF | PCplus4F, 32'h0);

    // Straight line from RESET_PC, 1-cycle memory.
    lat = 1;
    load_exp(RST_PC);
    reset = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RST_PC);
    check("c1_valid", 32'(FetchValidF), 32'd0);
    next_cycle();
    check("c2_valid", 32'(FetchValidF), 32'd0);
    next_cycle();
    check("c3_pc", PCF, 32'h100);
    next_cycle();
    check("c4_pc", PCF, 32'h104);
    next_cycle();
    check("c5_pc", PCF, 32'h108);

    // Stall five cycles while 0x108 is at the head.
    StallF = 1'b1;
    snap_pc = PCF; snap_instr = InstrF; snap_pc4 = PCplus4F;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_pc", PCF, snap_pc);
      check("stall_instr", InstrF, snap_instr);
      check("stall_pc4", PCplus4F, snap_pc4);
      if (i == 4) check("stall_req_drop", 32'(imem_req), 32'd0);
      next_cycle();
    end
    StallF = 1'b0;
    repeat (8) next_cycle();

    // Backpressure: no grants for four cycles.
    imem_gnt = 1'b0;
    snap_addr = imem_addr;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_req", 32'(imem_req), 32'd1);
      check("bp_addr", imem_addr, snap_addr);
      if (i == 3) check("bp_bubble", 32'(FetchValidF), 32'd0);
      next_cycle();
    end
    imem_gnt = 1'b1;
    repeat (8) next_cycle();

    // Redirect with two stale requests in flight, 3-cycle memory.
    do_reset(3);
    reset = 1'b1;
    next_cycle();
    next_cycle();
    PCSrcE = 1'b1;
    PCTargetE = 32'h0000_2002;
    load_exp(32'h2000);
    #1;
    check("redir_no_req", 32'(imem_req), 32'd0);
    next_cycle();
    PCSrcE = 1'b0;
    #1;
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h2000);
    check("redir_bubble", 32'(FetchValidF), 32'd0);
    wait_first_valid("redir_first", 32'h2000, 12);
    repeat (10) next_cycle();

    // Redirect coincident with a response and a stall.
    do_reset(1);
    load_exp(RST_PC);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (imem_rvalid && FetchValidF) break;
    end
    check("coinc_setup_rvalid", 32'(imem_rvalid), 32'd1);
    StallF = 1'b1;
    PCSrcE = 1'b1;
    PCTargetE = 32'h0000_3000;
    load_exp(32'h3000);
    next_cycle();
    StallF = 1'b0;
    PCSrcE = 1'b0;
    #1;
    check("coinc_bubble", 32'(FetchValidF), 32'd0);
    check("coinc_addr", imem_addr, 32'h3000);
    wait_first_valid("coinc_first", 32'h3000, 8);
    repeat (6) next_cycle();

    // Asynchronous reset mid-stream with the queue full.
    do_reset(1);
    load_exp(RST_PC);
    reset = 1'b1;
    repeat (3) next_cycle();
    StallF = 1'b1;
    repeat (6) next_cycle();
    check("full_valid", 32'(FetchValidF), 32'd1);
    check("full_no_req", 32'(imem_req), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_valid", 32'(FetchValidF), 32'd0);
    check("arst_outs", InstrF | PCF | PCplus4F, 32'h0);
    StallF = 1'b0;
    repeat (2) next_cycle();
    load_exp(RST_PC);
    reset = 1'b1;
    #1;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RST_PC);
    wait_first_valid("restart_first", RST_PC, 6);
    repeat (6) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
